// File: rtl/vga_sprite_compositor.sv
// rtl/vga_sprite_compositor.sv - VGA timing generator and two-sprite compositor
// Drives DrawX/DrawY to the sprite producers and merges their answers into 24-bit VGA colour.
module vga_sprite_compositor #(
  parameter int          H_VISIBLE       = 640,
  parameter int          H_FRONT         = 16,
  parameter int          H_SYNC          = 96,
  parameter int          H_BACK          = 48,
  parameter int          V_VISIBLE       = 480,
  parameter int          V_FRONT         = 10,
  parameter int          V_SYNC          = 2,
  parameter int          V_BACK          = 33,
  parameter logic [7:0]  TRANSPARENT_IDX = 8'h00
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       is_fireboy,
  input  logic [7:0] fireboy_data,
  input  logic       is_icegirl,
  input  logic [7:0] icegirl_data,
  input  logic [7:0] background_data,
  output logic       pixel_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_clk,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic       r_pixel_en;
  logic [9:0] r_draw_x;
  logic [9:0] r_draw_y;
  logic       r_frame_clk;

  logic       r_s1_fb;
  logic       r_s1_ig;
  logic       r_s1_hs;
  logic       r_s1_vs;
  logic       r_s1_blank_n;

  logic       r_hs;
  logic       r_vs;
  logic       r_blank_n;
  logic [7:0] r_red;
  logic [7:0] r_green;
  logic [7:0] r_blue;

  logic [9:0] w_next_x;
  logic [9:0] w_next_y;
  logic       w_vs_next;
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic       w_blank_n_raw;
  logic [7:0] w_pix;
  logic [7:0] w_red;
  logic [7:0] w_green;
  logic [7:0] w_blue;

  always_comb begin
    w_next_x = r_draw_x;
    w_next_y = r_draw_y;
    if (r_pixel_en) begin
      if (r_draw_x == H_LAST) begin
        w_next_x = 10'd0;
        w_next_y = (r_draw_y == V_LAST) ? 10'd0 : r_draw_y + 10'd1;
      end else begin
        w_next_x = r_draw_x + 10'd1;
      end
    end
  end

  // frame_clk follows the counter with no delay, so it is computed from the next line number
  assign w_vs_next     = !((w_next_y >= VS_FIRST) && (w_next_y <= VS_LAST));
  assign w_hs_raw      = !((r_draw_x >= HS_FIRST) && (r_draw_x <= HS_LAST));
  assign w_vs_raw      = !((r_draw_y >= VS_FIRST) && (r_draw_y <= VS_LAST));
  assign w_blank_n_raw = (r_draw_x < H_VIS) && (r_draw_y < V_VIS);

  always_comb begin
    w_pix = background_data;
    if (r_s1_fb && (fireboy_data != TRANSPARENT_IDX)) begin
      w_pix = fireboy_data;
    end else if (r_s1_ig && (icegirl_data != TRANSPARENT_IDX)) begin
      w_pix = icegirl_data;
    end
  end

  always_comb begin
    w_red   = 8'h00;
    w_green = 8'h00;
    w_blue  = 8'h00;
    if (r_s1_blank_n) begin
      w_red   = {w_pix[7:5], w_pix[7:5], w_pix[7:6]};
      w_green = {w_pix[4:2], w_pix[4:2], w_pix[4:3]};
      w_blue  = {w_pix[1:0], w_pix[1:0], w_pix[1:0], w_pix[1:0]};
    end
  end

  // Stage 1 takes the combinational hit flags; stage 2 meets the 1-cycle ROM data
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pixel_en   <= 1'b0;
      r_draw_x     <= 10'd0;
      r_draw_y     <= 10'd0;
      r_frame_clk  <= 1'b1;
      r_s1_fb      <= 1'b0;
      r_s1_ig      <= 1'b0;
      r_s1_hs      <= 1'b1;
      r_s1_vs      <= 1'b1;
      r_s1_blank_n <= 1'b0;
      r_hs         <= 1'b1;
      r_vs         <= 1'b1;
      r_blank_n    <= 1'b0;
      r_red        <= 8'h00;
      r_green      <= 8'h00;
      r_blue       <= 8'h00;
    end else begin
      r_pixel_en   <= ~r_pixel_en;
      r_draw_x     <= w_next_x;
      r_draw_y     <= w_next_y;
      r_frame_clk  <= w_vs_next;
      r_s1_fb      <= is_fireboy;
      r_s1_ig      <= is_icegirl;
      r_s1_hs      <= w_hs_raw;
      r_s1_vs      <= w_vs_raw;
      r_s1_blank_n <= w_blank_n_raw;
      r_hs         <= r_s1_hs;
      r_vs         <= r_s1_vs;
      r_blank_n    <= r_s1_blank_n;
      r_red        <= w_red;
      r_green      <= w_green;
      r_blue       <= w_blue;
    end
  end

  assign pixel_en    = r_pixel_en;
  assign DrawX       = r_draw_x;
  assign DrawY       = r_draw_y;
  assign frame_clk   = r_frame_clk;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_R       = r_red;
  assign VGA_G       = r_green;
  assign VGA_B       = r_blue;

endmodule
